// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types, constants and range-mask helper for the random request arbiter
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAW    = 2'd1,
    DELIVER = 2'd2
  } rand_state_t;

  localparam logic [31:0] SEED_DEFAULT = 32'h6B1CCA14;
  localparam logic [31:0] LFSR_LOCKUP  = 32'hFFFFFFFF;

  // Smallest 2^k-1 covering LIMIT-1; LIMIT of 0 selects the full byte range.
  function automatic logic [7:0] limit_mask(input logic [7:0] limit);
    logic [7:0] v;
    if (limit == 8'd0) begin
      return 8'hFF;
    end
    v = limit - 8'd1;
    v = v | (v >> 1);
    v = v | (v >> 2);
    v = v | (v >> 4);
    return v;
  endfunction

endpackage

// File: rtl/rand_request_arbiter_if.sv
// rtl/rand_request_arbiter_if.sv - requester-side bus of the random request arbiter
interface rand_request_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   REQ;
  logic [8*NUM_REQ-1:0] LIMIT;
  logic                 RESEED;
  logic [31:0]          RESEED_VAL;
  logic [NUM_REQ-1:0]   GNT;
  logic [7:0]           RAND_OUT;
  logic                 VALID;
  logic                 BUSY;

  modport master (
    output REQ, LIMIT, RESEED, RESEED_VAL,
    input  GNT, RAND_OUT, VALID, BUSY
  );

  modport slave (
    input  REQ, LIMIT, RESEED, RESEED_VAL,
    output GNT, RAND_OUT, VALID, BUSY
  );
endinterface

// File: rtl/lfsr32_step.sv
// rtl/lfsr32_step.sv - 32-bit XNOR LFSR (taps 32,22,2,1) with load and step enable
module lfsr32_step
  import rand_pkg::*;
#(
  parameter logic [31:0] SEED = SEED_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [31:0] LOAD_VAL,
  output logic [31:0] Q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q <= SEED;
    end else if (LOAD) begin
      Q <= LOAD_VAL;
    end else if (EN) begin
      Q <= {Q[30:0], ~(Q[31] ^ Q[21] ^ Q[1] ^ Q[0])};
    end
  end

endmodule

// File: rtl/rand_request_arbiter.sv
// rtl/rand_request_arbiter.sv - round-robin arbiter handing out bounded random bytes from a shared LFSR
module rand_request_arbiter
  import rand_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] SEED      = SEED_DEFAULT,
  parameter int          MAX_TRIES = 8
) (
  input logic                   CLK,
  input logic                   RST,
  rand_request_arbiter_if.slave bus
);

  localparam int         PTR_W     = $clog2(NUM_REQ);
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

  rand_state_t      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [7:0]       lim_q, lim_d;
  logic [3:0]       tries_q, tries_d;
  logic [7:0]       rand_q, rand_d;

  logic [31:0]      lfsr_q;
  logic [31:0]      load_val;
  logic             arb_hit;
  logic [PTR_W-1:0] arb_idx;
  logic [PTR_W-1:0] arb_j;
  logic [7:0]       arb_lim;
  logic [7:0]       cand;
  logic             accept;
  logic             unused_lfsr_hi;

  // Reseeding with the XNOR lock-up state would freeze the generator.
  assign load_val = (bus.RESEED_VAL == LFSR_LOCKUP) ? SEED : bus.RESEED_VAL;

  lfsr32_step #(.SEED(SEED)) u_lfsr (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (state_q == DRAW),
    .LOAD     ((state_q == IDLE) && bus.RESEED),
    .LOAD_VAL (load_val),
    .Q        (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[31:8];

  // First requester strictly after the pointer wins, wrapping around.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    arb_j   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_j = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!arb_hit && bus.REQ[arb_j]) begin
        arb_hit = 1'b1;
        arb_idx = arb_j;
      end
    end
  end

  assign arb_lim = bus.LIMIT[{arb_idx, 3'b000} +: 8];
  assign cand    = lfsr_q[7:0] & limit_mask(lim_q);
  assign accept  = (lim_q == 8'd0) || (cand < lim_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    lim_d   = lim_q;
    tries_d = tries_q;
    rand_d  = rand_q;
    case (state_q)
      IDLE: begin
        if (!bus.RESEED && arb_hit) begin
          win_d   = arb_idx;
          lim_d   = arb_lim;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (accept) begin
          rand_d  = cand;
          state_d = DELIVER;
        end else if (tries_q + 4'd1 == TRIES_MAX) begin
          // cand <= mask < 2*LIMIT, so the folded value is always in range.
          rand_d  = cand - lim_q;
          state_d = DELIVER;
        end else begin
          tries_d = tries_q + 4'd1;
        end
      end
      DELIVER: begin
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      win_q   <= '0;
      lim_q   <= '0;
      tries_q <= '0;
      rand_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      lim_q   <= lim_d;
      tries_q <= tries_d;
      rand_q  <= rand_d;
    end
  end

  assign bus.GNT      = (state_q == DELIVER) ? (NUM_REQ'(1) << win_q) : '0;
  assign bus.VALID    = (state_q == DELIVER);
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.RAND_OUT = rand_q;

endmodule
